// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: constants and types shared by the round-robin grant controller
// and its mask generator.
package rr_arb_pkg;

  localparam int N_REQ        = 4;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : rr_arb_pkg

// File: rtl/rr_mask_gen.sv
// rr_mask_gen: round-robin mask register and masked-request mux.
// The mask keeps only the request lines strictly above the most recent
// winner.  When no masked request is pending, the raw request vector is
// passed through so the search wraps around to index 0.
module rr_mask_gen
  import rr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_load,
  input  logic [N_REQ-1:0] i_gnt_onehot,
  output logic [N_REQ-1:0] o_pri_in
);

  logic [N_REQ-1:0] r_mask;
  logic [N_REQ-1:0] w_below;
  logic [N_REQ-1:0] w_masked;

  // For a one-hot winner g, (g | (g - 1)) covers g and every lower bit,
  // so its complement is exactly the bits strictly above the winner.
  assign w_below  = i_gnt_onehot - {{(N_REQ-1){1'b0}}, 1'b1};
  assign w_masked = i_req & r_mask;

  // Masked requests take precedence; an empty masked set falls back to req.
  always_comb begin
    o_pri_in = i_req;
    if (|w_masked) begin
      o_pri_in = w_masked;
    end
  end

  // Mask register: all-ones after reset, reloaded on every new grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '1;
    end else if (i_load) begin
      r_mask <= ~(i_gnt_onehot | w_below);
    end
  end

endmodule : rr_mask_gen

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant controller for four requesters.
// The lowest-index pick is done by an external priority stage: this block
// drives the rotated request vector on pri_in/pri_en and registers the
// one-hot answer from pri_out as the grant.  A grant is held while its
// owner keeps requesting; after a release there is one idle cycle before
// the next winner is loaded.
// Optional feature: define RR_TIMEOUT_EN to build an 8-bit hold counter
// that forces a release after MAX_HOLD consecutive grant cycles.
//
// Handshake: pri_en is a combinational request to the priority stage and is
// high only in IDLE with a pending request; pri_out is consumed on the same
// rising edge and must then be one-hot, otherwise err is set (sticky).
module rr_grant_ctrl
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] pri_out,
  output logic [N_REQ-1:0] pri_in,
  output logic             pri_en,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             err,
  output state_t           dbg_state
);

  // Elaboration-time guard on the hold limit.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("rr_grant_ctrl: MAX_HOLD must be in 2..255");
  end

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic             r_gnt_valid;
  logic             r_err;

  logic             w_pri_onehot;
  logic             w_grant_load;
  logic             w_own_req;
  logic             w_timeout;

`ifdef RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;

  assign w_timeout = (r_hold_cnt == HOLD_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // One-hot test: non-zero with no two bits set.
  assign w_pri_onehot = (pri_out != '0) &&
                        ((pri_out & (pri_out - {{(N_REQ-1){1'b0}}, 1'b1})) == '0);

  assign pri_en       = (r_state == IDLE) && (|req);
  assign w_grant_load = pri_en && w_pri_onehot;
  assign w_own_req    = |(req & r_gnt);

  assign gnt          = r_gnt;
  assign gnt_valid    = r_gnt_valid;
  assign err          = r_err;
  assign dbg_state    = r_state;

  rr_mask_gen u_mask_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (req),
    .i_load       (w_grant_load),
    .i_gnt_onehot (pri_out),
    .o_pri_in     (pri_in)
  );

  // Grant FSM with registered grant, valid, error and hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_err       <= 1'b0;
`ifdef RR_TIMEOUT_EN
      r_hold_cnt  <= 8'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (pri_en) begin
            if (w_pri_onehot) begin
              r_gnt       <= pri_out;
              r_gnt_valid <= 1'b1;
              r_state     <= GRANT;
`ifdef RR_TIMEOUT_EN
              r_hold_cnt  <= 8'd0;
`endif
            end else begin
              // Priority stage broke the one-hot contract: flag and stay idle.
              r_err <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (!w_own_req || w_timeout) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_state     <= IDLE;
          end else begin
`ifdef RR_TIMEOUT_EN
            r_hold_cnt  <= r_hold_cnt + 8'd1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : rr_grant_ctrl

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 The parameter list SHALL be: MAX_HOLD, 16, maximum consecutive grant cycles per owner; used only when RR_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  raw request lines; bit i is requester i; level-held until served.
REQ-005 pri_out  input  4  one-hot winner returned by the downstream priority stage; lowest set index wins.
REQ-006 pri_in  output  4  rotated/masked request vector driven to the priority stage.
REQ-007 pri_en  output  1  enable to the priority stage.
REQ-008 gnt  output  4  registered one-hot grant; 4'b0000 when no owner.
REQ-009 gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-010 err  output  1  sticky; set on a protocol violation by the priority stage.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 The block SHALL keep a 4-bit mask register; pri_in SHALL equal req & mask when that is non-zero, and req otherwise.
REQ-013 pri_en SHALL be combinational: high only in IDLE with |req; low in GRANT.
REQ-014 In IDLE with pri_en high and pri_out one-hot, the next edge SHALL load gnt <= pri_out, set gnt_valid, and enter GRANT; latency is one cycle from request sampled to grant visible.
REQ-015 On each grant of index k, mask SHALL load the bits strictly above k: k=0 gives 1110, k=1 gives 1100, k=2 gives 1000, k=3 gives 0000, which falls back to the full req.
REQ-016 In GRANT, the grant SHALL hold while req[k] stays high; requests on other lines SHALL be ignored.
REQ-017 In GRANT with req[k] sampled low, the edge SHALL clear gnt and gnt_valid and return to IDLE.
REQ-018 After a release there SHALL be exactly one IDLE cycle with gnt = 0; re-arbitration takes effect on the following edge.
REQ-019 In IDLE with pri_en high and pri_out = 0 or not one-hot, the block SHALL stay in IDLE, keep gnt = 0, and set err; err clears only on reset.
REQ-020 In IDLE with req = 0, state, mask and gnt SHALL be unchanged.

Reset
REQ-021 Asserting reset_n low SHALL immediately force gnt = 0, gnt_valid = 0, err = 0, state = IDLE, mask = 4'b1111 and hold counter = 0, including mid-GRANT.
REQ-022 After reset release, the first arbitration SHALL favour index 0 because the mask is 1111.

Configuration
REQ-023 With RR_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-024 With RR_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 with req[k] still high, the next edge SHALL force a release exactly as in REQ-017; the rotated mask then lets other requesters win first.
REQ-025 Without RR_TIMEOUT_EN, the counter SHALL not be built, MAX_HOLD SHALL be ignored, and a grant SHALL be held indefinitely.

Structure
REQ-026 A shared package rr_arb_pkg SHALL hold N_REQ = 4, the FSM state typedef (IDLE, GRANT), and the default MAX_HOLD constant.
REQ-027 The mask register and the masked-request mux SHALL live in one sub-module, rr_mask_gen; the FSM, grant register and counter SHALL stay in rr_grant_ctrl.

Verification
REQ-028 Reset, then req = 0101 held: gnt = 0001 one cycle later; drop req[0]: gnt = 0000 for one cycle, then gnt = 0100.
REQ-029 req = 1111 with each owner dropping its request after 2 cycles: grant order SHALL be 0001, 0010, 0100, 1000, 0001.
REQ-030 Mid-GRANT (gnt = 0010), assert reset_n low between clock edges: gnt = 0000 immediately; after release, with req = 1111, gnt = 0001.
REQ-031 Force pri_out = 0000 while pri_en = 1: err = 1 after the edge, gnt stays 0000, err persists until reset.
REQ-032 RR_TIMEOUT_EN, MAX_HOLD = 4, req = 0011 held: gnt = 0001 for 4 cycles, 0000 for 1, then 0010.
REQ-033 Same stimulus without RR_TIMEOUT_EN: gnt = 0001 for 100 cycles.
